linear_stream: RTL and testbench

- Time-multiplexed fully connected layer and parametrised successor to the fixed 196-in/10-out linear layer.
- Input features arrive serially, one signed BITWIDTH beat per handshake. Each beat is multiplied against a full weight column fetched from an external weight store, across OUT_FEATURES parallel MAC lanes.
- After the last beat, each lane receives optional bias, arithmetic right shift, optional ReLU and saturation. The result vector is then held under a valid/ready handshake.
- Sits between a feature-producing stage (conv/pool flattener) and a classifier or the next layer.

---
 rtl/linear_stream_if.sv | 32 +++
 rtl/linear_stream.sv | 131 +++++++++++++
 tb/tb_linear_stream.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/linear_stream_if.sv
// Stream and memory-side signals of the time-multiplexed linear layer.
// The slave modport is the layer itself; the master modport is its environment
// (feature producer, weight/bias store and result consumer).
interface linear_stream_if #(
   parameter int BITWIDTH     = 8,
   parameter int OUT_WIDTH    = 16,
   parameter int IN_FEATURES  = 196,
   parameter int OUT_FEATURES = 10
);
   localparam int AW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;

   logic                               in_valid;
   logic                               in_ready;
   logic [BITWIDTH-1:0]                in_data;
   logic [AW-1:0]                      weight_addr;
   logic [OUT_FEATURES*BITWIDTH-1:0]   weight_data;
   logic [OUT_FEATURES*OUT_WIDTH-1:0]  bias_mem;
   logic                               out_valid;
   logic                               out_ready;
   logic [OUT_FEATURES*OUT_WIDTH-1:0]  out_features;
   logic                               busy;

   modport slave (
      input  in_valid, in_data, weight_data, bias_mem, out_ready,
      output in_ready, weight_addr, out_valid, out_features, busy
   );

   modport master (
      output in_valid, in_data, weight_data, bias_mem, out_ready,
      input  in_ready, weight_addr, out_valid, out_features, busy
   );
endinterface

// File: rtl/linear_stream.sv
// Time-multiplexed fully connected layer: one signed feature per beat is
// multiplied against a full weight column across OUT_FEATURES MAC lanes.
// After the last beat each lane gets bias, arithmetic shift, ReLU and
// saturation, and the vector is held under a valid/ready handshake.
module linear_stream #(
   parameter int BITWIDTH     = 8,
   parameter int ACC_WIDTH    = 32,
   parameter int OUT_WIDTH    = 16,
   parameter int IN_FEATURES  = 196,
   parameter int OUT_FEATURES = 10,
   parameter int USING_BIAS   = 0,
   parameter int USING_RELU   = 0,
   parameter int OUT_SHIFT    = 0
) (
   input  logic             clk,
   input  logic             rst,
   linear_stream_if.slave   bus
);
   localparam int AW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {S_ACC, S_POST, S_OUT} state_t;

   state_t                             state_q, state_d;
   logic [AW-1:0]                      count_q, count_d;
   logic signed [ACC_WIDTH-1:0]        acc_q [OUT_FEATURES];
   logic signed [ACC_WIDTH-1:0]        acc_d [OUT_FEATURES];
   logic [OUT_FEATURES*OUT_WIDTH-1:0]  out_features_q, out_features_d;
   logic                               out_valid_q, out_valid_d;

   logic signed [BITWIDTH-1:0]         x_in;
   logic signed [2*BITWIDTH-1:0]       prod [OUT_FEATURES];
   logic [OUT_FEATURES*OUT_WIDTH-1:0]  post_vec;
   logic                               beat;

   assign x_in            = bus.in_data;
   assign bus.in_ready    = (state_q == S_ACC) && !rst;
   assign bus.weight_addr = count_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_features = out_features_q;
   assign bus.busy        = (state_q != S_ACC) || (count_q != '0);
   assign beat            = bus.in_valid && bus.in_ready;

   // Per-lane products and post-processed results (bias, shift, ReLU, clamp)
   always_comb begin
      logic signed [BITWIDTH-1:0]  w_lane;
      logic signed [OUT_WIDTH-1:0] bias_lane;
      logic signed [ACC_WIDTH-1:0] bias_ext;
      logic signed [ACC_WIDTH-1:0] sum;
      logic signed [ACC_WIDTH-1:0] shifted;
      logic [OUT_WIDTH-1:0]        lane_out;
      post_vec = '0;
      for (int unsigned j = 0; j < OUT_FEATURES; j++) begin
         w_lane    = bus.weight_data[(OUT_FEATURES-1-j)*BITWIDTH +: BITWIDTH];
         prod[j]   = w_lane * x_in;
         bias_lane = bus.bias_mem[(OUT_FEATURES-1-j)*OUT_WIDTH +: OUT_WIDTH];
         bias_ext  = (USING_BIAS != 0) ? ACC_WIDTH'(bias_lane) : '0;
         sum       = acc_q[j] + bias_ext;
         shifted   = sum >>> OUT_SHIFT;
         if ((USING_RELU != 0) && (shifted < 0)) begin
            shifted = '0;
         end
         if (shifted > SAT_MAX) begin
            lane_out = SAT_MAX[OUT_WIDTH-1:0];
         end else if (shifted < SAT_MIN) begin
            lane_out = SAT_MIN[OUT_WIDTH-1:0];
         end else begin
            lane_out = shifted[OUT_WIDTH-1:0];
         end
         post_vec[(OUT_FEATURES-1-j)*OUT_WIDTH +: OUT_WIDTH] = lane_out;
      end
   end

   // Next-state logic: accumulate beats, one post-processing cycle, then hold
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      acc_d          = acc_q;
      out_features_d = out_features_q;
      out_valid_d    = out_valid_q;
      unique case (state_q)
         S_ACC: begin
            if (beat) begin
               for (int unsigned j = 0; j < OUT_FEATURES; j++) begin
                  acc_d[j] = acc_q[j] + ACC_WIDTH'(prod[j]);
               end
               if (count_q == AW'(IN_FEATURES - 1)) begin
                  count_d = '0;
                  state_d = S_POST;
               end else begin
                  count_d = count_q + AW'(1);
               end
            end
         end
         S_POST: begin
            out_features_d = post_vec;
            for (int unsigned j = 0; j < OUT_FEATURES; j++) begin
               acc_d[j] = '0;
            end
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_ACC;
            end
         end
         default: state_d = S_ACC;
      endcase
   end

   // State registers; reset discards partial sums and any pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_ACC;
         count_q        <= '0;
         acc_q          <= '{default: '0};
         out_features_q <= '0;
         out_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         acc_q          <= acc_d;
         out_features_q <= out_features_d;
         out_valid_q    <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_linear_stream.sv
// Bench for linear_stream: three configurations share one stimulus stream and
// are compared against an arithmetic reference of the layer.
module tb_linear_stream;
   localparam int BW   = 8;
   localparam int IN   = 4;
   localparam int OUTF = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid;
   logic [BW-1:0] in_data;
   logic          out_ready;

   int x_cur [IN];
   int w     [OUTF][IN];
   int bias  [OUTF];

   int n_tests = 0;
   int n_fail  = 0;

   linear_stream_if #(.BITWIDTH(BW), .OUT_WIDTH(16), .IN_FEATURES(IN), .OUT_FEATURES(OUTF)) if0 ();
   linear_stream_if #(.BITWIDTH(BW), .OUT_WIDTH(8),  .IN_FEATURES(IN), .OUT_FEATURES(OUTF)) if1 ();
   linear_stream_if #(.BITWIDTH(BW), .OUT_WIDTH(8),  .IN_FEATURES(IN), .OUT_FEATURES(OUTF)) if2 ();

   assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
   assign if0.in_data  = in_data;   assign if1.in_data  = in_data;   assign if2.in_data  = in_data;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;
   assign if0.weight_data = {8'(w[0][if0.weight_addr]), 8'(w[1][if0.weight_addr])};
   assign if1.weight_data = {8'(w[0][if1.weight_addr]), 8'(w[1][if1.weight_addr])};
   assign if2.weight_data = {8'(w[0][if2.weight_addr]), 8'(w[1][if2.weight_addr])};
   assign if0.bias_mem = {16'(bias[0]), 16'(bias[1])};
   assign if1.bias_mem = {8'(bias[0]), 8'(bias[1])};
   assign if2.bias_mem = {8'(bias[0]), 8'(bias[1])};

   linear_stream #(.BITWIDTH(BW), .ACC_WIDTH(32), .OUT_WIDTH(16), .IN_FEATURES(IN), .OUT_FEATURES(OUTF),
                   .USING_BIAS(1), .USING_RELU(0), .OUT_SHIFT(0))
      u0 (.clk(clk), .rst(rst), .bus(if0));
   linear_stream #(.BITWIDTH(BW), .ACC_WIDTH(32), .OUT_WIDTH(8), .IN_FEATURES(IN), .OUT_FEATURES(OUTF),
                   .USING_BIAS(0), .USING_RELU(0), .OUT_SHIFT(2))
      u1 (.clk(clk), .rst(rst), .bus(if1));
   linear_stream #(.BITWIDTH(BW), .ACC_WIDTH(32), .OUT_WIDTH(8), .IN_FEATURES(IN), .OUT_FEATURES(OUTF),
                   .USING_BIAS(1), .USING_RELU(1), .OUT_SHIFT(2))
      u2 (.clk(clk), .rst(rst), .bus(if2));

   logic signed [15:0] o0 [OUTF];
   logic signed [7:0]  o1 [OUTF];
   logic signed [7:0]  o2 [OUTF];
   assign o0[0] = if0.out_features[31:16];
   assign o0[1] = if0.out_features[15:0];
   assign o1[0] = if1.out_features[15:8];
   assign o1[1] = if1.out_features[7:0];
   assign o2[0] = if2.out_features[15:8];
   assign o2[1] = if2.out_features[7:0];

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Dot product wraps modulo 2^32 (int arithmetic), then bias, floor division
   // by 2^sh, optional ReLU and clamp to the signed ow-bit range.
   function automatic longint model(input int j, input int ow, input bit use_bias,
                                    input bit relu, input int sh);
      int     s = 0;
      longint v, d, q, hi, lo;
      for (int k = 0; k < IN; k++) s += x_cur[k] * w[j][k];
      if (use_bias) s += bias[j];
      v = longint'(s);
      d = longint'(1) << sh;
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      if (relu && q < 0) q = 0;
      hi = (longint'(1) << (ow - 1)) - 1;
      lo = -(longint'(1) << (ow - 1));
      if (q > hi) q = hi;
      if (q < lo) q = lo;
      return q;
   endfunction

   task automatic check_outputs();
      for (int j = 0; j < OUTF; j++) begin
         check($sformatf("u0_lane%0d", j), longint'(o0[j]), model(j, 16, 1'b1, 1'b0, 0));
         check($sformatf("u1_lane%0d", j), longint'(o1[j]), model(j, 8,  1'b0, 1'b0, 2));
         check($sformatf("u2_lane%0d", j), longint'(o2[j]), model(j, 8,  1'b1, 1'b1, 2));
      end
   endtask

   // mode 0: gap-free, 1: fixed bubble pattern, 2: random bubbles.
   // hold: cycles of out_ready low while the result is pending.
   task automatic run_vector(input int mode, input int hold);
      int     k = 0;
      int     cyc = 0;
      int     p = 0;
      bit     accepted;
      bit     patt [7] = '{1, 0, 0, 1, 0, 1, 1};
      longint snap0, snap1, snap2;
      while (k < IN && cyc < 200) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       in_valid = patt[p % 7];
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         p++;
         in_data = in_valid ? 8'(x_cur[k]) : 8'($urandom);
         @(negedge clk);
         check("weight_addr", longint'(if0.weight_addr), longint'(k));
         check("in_ready_acc", longint'(if0.in_ready), 1);
         accepted = in_valid && if0.in_ready;
         @(posedge clk); #1;
         cyc++;
         if (accepted) k++;
      end
      if (k < IN) check("beat_timeout", longint'(k), longint'(IN));
      in_valid = 1'b0;
      check("post_out_valid", longint'(if0.out_valid), 0);
      check("post_in_ready", longint'(if0.in_ready), 0);
      check("post_busy", longint'(if0.busy), 1);
      check("addr_wrap", longint'(if0.weight_addr), 0);
      @(posedge clk); #1;
      check("u0_out_valid", longint'(if0.out_valid), 1);
      check("u1_out_valid", longint'(if1.out_valid), 1);
      check("u2_out_valid", longint'(if2.out_valid), 1);
      check_outputs();
      snap0 = longint'(if0.out_features);
      snap1 = longint'(if1.out_features);
      snap2 = longint'(if2.out_features);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", longint'(if0.out_valid), 1);
         check("hold_feat0", longint'(if0.out_features), snap0);
         check("hold_feat1", longint'(if1.out_features), snap1);
         check("hold_feat2", longint'(if2.out_features), snap2);
         check("hold_in_ready", longint'(if0.in_ready), 0);
         check("hold_addr", longint'(if0.weight_addr), 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_out_valid", longint'(if0.out_valid), 0);
      check("hs_in_ready", longint'(if0.in_ready), 1);
      check("hs_busy", longint'(if0.busy), 0);
      check("hs_feat_kept", longint'(if0.out_features), snap0);
   endtask

   task automatic load_plan_vector();
      for (int k = 0; k < IN; k++) begin
         x_cur[k] = k + 1;
         w[0][k]  = 1;
         w[1][k]  = -1;
      end
      bias[0] = 5;
      bias[1] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'($urandom);
      out_ready = 1'b0;
      load_plan_vector();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", longint'(if0.in_ready), 0);
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("rst_out_valid", longint'(if0.out_valid), 0);
      check("rst_busy", longint'(if0.busy), 0);
      check("rst_addr", longint'(if0.weight_addr), 0);
      check("rst_feat0", longint'(if0.out_features), 0);
      check("rst_feat1", longint'(if1.out_features), 0);
      check("rst_feat2", longint'(if2.out_features), 0);

      // Reference vector with backpressure
      run_vector(0, 5);
      check("plan_lane0", longint'(o0[0]), 15);
      check("plan_lane1", longint'(o0[1]), -10);

      // Saturation
      for (int k = 0; k < IN; k++) begin
         x_cur[k] = 127; w[0][k] = 127; w[1][k] = -127;
      end
      bias[0] = 0; bias[1] = 0;
      run_vector(0, 1);
      check("sat_hi", longint'(o1[0]), 127);
      check("sat_lo", longint'(o1[1]), -128);

      // Shift and ReLU on accumulators 10 and -10
      for (int k = 0; k < IN; k++) begin
         x_cur[k] = (k == 0) ? 1 : 0; w[0][k] = 10; w[1][k] = -10;
      end
      run_vector(0, 0);
      check("shift_pos", longint'(o1[0]), 2);
      check("shift_neg", longint'(o1[1]), -3);
      check("relu_pos", longint'(o2[0]), 2);
      check("relu_neg", longint'(o2[1]), 0);

      // Bubbles
      load_plan_vector();
      run_vector(1, 2);
      check("bubble_lane0", longint'(o0[0]), 15);
      check("bubble_lane1", longint'(o0[1]), -10);

      // Reset after two beats
      in_valid = 1'b1;
      in_data  = 8'(x_cur[0]);
      @(posedge clk); #1;
      in_data  = 8'(x_cur[1]);
      @(posedge clk); #1;
      check("mid_busy", longint'(if0.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", longint'(if0.in_ready), 0);
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      check("mid_rst_busy", longint'(if0.busy), 0);
      check("mid_rst_valid", longint'(if0.out_valid), 0);
      check("mid_rst_addr", longint'(if0.weight_addr), 0);
      run_vector(0, 2);
      check("after_rst_lane0", longint'(o0[0]), 15);
      check("after_rst_lane1", longint'(o0[1]), -10);

      // Randomized vectors
      for (int v = 0; v < 25; v++) begin
         for (int k = 0; k < IN; k++) begin
            x_cur[k] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < OUTF; j++) w[j][k] = int'($urandom_range(0, 255)) - 128;
         end
         for (int j = 0; j < OUTF; j++) bias[j] = int'($urandom_range(0, 255)) - 128;
         run_vector(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
